// File: rtl/sram_arbiter_2x1_if.sv
// SRAM-like request/response bundle: one instance per master and one for the
// shared slave channel.
interface sram_arbiter_2x1_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          addr_ok;
  logic          data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_arbiter_2x1.sv
// Round-robin arbiter of two SRAM-like masters onto one slave channel, with an
// in-order ID FIFO that routes each response back to its issuing master.
module sram_arbiter_2x1 #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  sram_arbiter_2x1_if.slave  m0,
  sram_arbiter_2x1_if.slave  m1,
  sram_arbiter_2x1_if.master s
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          owner_q;
  logic          owner_d;
  logic          rr_prio_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          fifo_q [DEPTH];

  logic          full;
  logic          gnt_vld;
  logic          gnt_id;
  logic          accept;
  logic          pop;
  logic          head_id;
  logic          gnt_wr;
  logic [1:0]    gnt_size;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  assign full = (count_q == CW'(DEPTH));

  // Grant selection and IDLE/LOCK next-state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!full) begin
          if (m0.req && m1.req) begin
            gnt_vld = 1'b1;
            gnt_id  = rr_prio_q;
          end else if (m0.req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
          end else if (m1.req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
          end
        end
        if (gnt_vld && !s.addr_ok) begin
          state_d = LOCK;
          owner_d = gnt_id;
        end
      end
      LOCK: begin
        // Owner keeps the channel until accepted; a dropped req abandons it.
        gnt_id  = owner_q;
        gnt_vld = owner_q ? m1.req : m0.req;
        if (!gnt_vld || s.addr_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_wr    = gnt_id ? m1.wr    : m0.wr;
  assign gnt_size  = gnt_id ? m1.size  : m0.size;
  assign gnt_addr  = gnt_id ? m1.addr  : m0.addr;
  assign gnt_wdata = gnt_id ? m1.wdata : m0.wdata;

  assign s.req   = gnt_vld & ~rst;
  assign s.wr    = gnt_wr;
  assign s.size  = gnt_size;
  assign s.addr  = gnt_addr;
  assign s.wdata = gnt_wdata;

  assign accept  = gnt_vld & ~rst & s.addr_ok;
  assign head_id = fifo_q[rd_ptr_q];
  // Responses arriving with nothing outstanding (e.g. after reset) are dropped.
  assign pop     = s.data_ok & (count_q != '0) & ~rst;

  assign m0.addr_ok = accept & ~gnt_id;
  assign m1.addr_ok = accept &  gnt_id;
  assign m0.data_ok = pop & ~head_id;
  assign m1.data_ok = pop &  head_id;
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_prio_q <= 1'b1;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (accept) begin
        rr_prio_q <= ~gnt_id;
        wr_ptr_q  <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ID storage; validity is tracked by count/pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= gnt_id;
    end
  end
endmodule

// File: doc/sram_arbiter_2x1.md
Name: sram_arbiter_2x1

Overview:
- Arbitrates two sram-like masters onto one sram-like slave port: m0 is the instruction-side requester and m1 the data-side requester.
- Sits between the cache/bridge layer and cpu_axi_interface, so both requesters can share one slave channel.
- Tracks accepted-but-unanswered transactions in an in-order ID FIFO, so each data_ok/rdata is routed back to the master that issued it.
- Round-robin between masters; the grant stays locked while a presented request waits for addr_ok.

Parameters:
- DEPTH, 4, maximum outstanding accepted transactions (power of 2, ≥2).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req, m1_req  in  1  master request.
- m0_wr, m1_wr  in  1  1 = write.
- m0_size, m1_size  in  2  0 = byte, 1 = half, 2 = word.
- m0_addr, m1_addr  in  AW  physical address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_rdata, m1_rdata  out  DW  read data (shared copy of s_rdata).
- m0_addr_ok, m1_addr_ok  out  1  request accepted.
- m0_data_ok, m1_data_ok  out  1  response returned.
- s_req  out  1  request to slave.
- s_wr  out  1  write flag to slave.
- s_size  out  2  access size to slave.
- s_addr  out  AW  address to slave.
- s_wdata  out  DW  write data to slave.
- s_rdata  in  DW  slave read data.
- s_addr_ok  in  1  slave accepts request.
- s_data_ok  in  1  slave returns response (in order).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE, FIFO count = 0, read/write pointers = 0, rr_prio = m1.
  - While rst=1, s_req, m0_addr_ok, m1_addr_ok, m0_data_ok and m1_data_ok are forced to 0.
- Reset mid-operation: outstanding entries are discarded. A later s_data_ok with count = 0 is ignored: no m*_data_ok, count stays 0.
- State IDLE:
  - When FIFO is full (count = DEPTH), there is no grant and s_req = 0.
  - Otherwise, if exactly one m*_req = 1, that master is granted in the same cycle (combinational, zero added latency).
  - If both are requesting, the master equal to rr_prio is granted.
  - Granted master's req/wr/size/addr/wdata drive s_* directly.
  - If s_addr_ok = 1 in that cycle, the request is accepted and the state stays IDLE.
  - Otherwise the owner is registered and the state moves to LOCK.
- State LOCK:
  - The grant is held on the registered owner regardless of the other master's req, so s_* stay stable until s_addr_ok.
  - s_addr_ok = 1 → accept, go to IDLE.
  - Owner drops req (protocol violation) → go to IDLE with no push.
  - Full cannot arise in LOCK, because entry to LOCK requires count < DEPTH and pops only reduce count.
- Accept cycle (s_req & s_addr_ok):
  - The granted master's m*_addr_ok = 1; the other master's addr_ok = 0.
  - The owner ID (0/1) is pushed into the FIFO.
  - rr_prio is set to the non-granted master.
  - rr_prio changes only on accept.
- Response cycle (s_data_ok):
  - The FIFO head ID selects the master: m<head>_data_ok = 1, the other master's data_ok = 0.
  - The head is popped.
  - m0_rdata = m1_rdata = s_rdata at all times.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Pointer width is log2(DEPTH); pointers wrap modulo DEPTH.
- Accept and data_ok for the same transaction cannot occur in the same cycle: the slave responds at the earliest one cycle after addr_ok.
- A push arriving while the FIFO is empty becomes the head on the next cycle.

Test Plan:
- Reset, then m0 only reads 0xBFC00000 with s_addr_ok = 1 in the same cycle, and s_data_ok 2 cycles later with s_rdata = 0x12345678 → m0_addr_ok pulses in cycle 0; m0_data_ok = 1 with m0_rdata = 0x12345678; m1_data_ok stays 0.
- Both masters request from reset with s_addr_ok held at 1 → grants go m1, m0, m1, m0 on consecutive cycles; FIFO order is 1, 0, 1, 0; four s_data_ok pulses go to m1, m0, m1, m0.
- m0 is granted with s_addr_ok = 0 for 3 cycles, and m1_req rises in cycle 1 → s_addr stays m0_addr through cycle 3; m0 is accepted in cycle 3; m1 is granted in cycle 4.
- DEPTH = 4, 4 accepts with no s_data_ok → 5th request gives s_req = 0; one s_data_ok, and in the next cycle a pending request is accepted; count never exceeds 4.
- With 2 outstanding transactions (m1 then m0), assert rst for one cycle, then pulse s_data_ok → neither m*_data_ok asserts; the next m0 accept/response completes normally.
- FIFO holds one m0 entry; an m1 accept and s_data_ok occur in the same cycle → m0_data_ok = 1; count stays 1; the head becomes m1.
